// File: rtl/maze_pkg.sv
// Shared MazeRunner types: remote command opcodes, sequencer states and the
// acknowledge byte the UART wrapper sends back.
package maze_pkg;

    typedef enum logic [2:0] {
        CAL   = 3'b000,
        HDG   = 3'b001,
        MOVE  = 3'b010,
        SOLVE = 3'b011
    } opcode_t;

    typedef enum logic [2:0] {
        StIdle,
        StCal,
        StHdg,
        StMove,
        StSolve
    } state_t;

    localparam logic [7:0] RESP_ACK = 8'hA5;

endpackage

// File: rtl/cmd_proc.sv
// Remote command sequencer: accepts one 16-bit command at a time, launches the
// matching unit and requests an acknowledge once that unit reports completion.
module cmd_proc
    import maze_pkg::*;
#(
    parameter int unsigned HDG_W = 12
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [15:0]      cmd,
    input  logic             cmd_rdy,
    output logic             clr_cmd_rdy,
    output logic             send_resp,
    output logic             strt_cal,
    input  logic             cal_done,
    output logic             in_cal,
    output logic             strt_hdng,
    output logic             strt_mv,
    output logic             stp_lft,
    output logic             stp_rght,
    output logic [HDG_W-1:0] dsrd_hdg,
    input  logic             mv_cmplt,
    output logic             cmd_md,
    output logic             lft_rght_pref,
    input  logic             sol_cmplt
);

    state_t state_q;

    // cmd[12] carries no meaning for any opcode.
    logic unused_cmd;
    assign unused_cmd = cmd[12];

    // clr_cmd_rdy is high exactly in the cycle after acceptance, so it doubles as
    // the guard that masks a stale done and stops re-accepting a word the wrapper
    // has not yet dropped.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= StIdle;
            clr_cmd_rdy   <= 1'b0;
            send_resp     <= 1'b0;
            strt_cal      <= 1'b0;
            in_cal        <= 1'b0;
            strt_hdng     <= 1'b0;
            strt_mv       <= 1'b0;
            stp_lft       <= 1'b0;
            stp_rght      <= 1'b0;
            dsrd_hdg      <= '0;
            cmd_md        <= 1'b1;
            lft_rght_pref <= 1'b0;
        end else begin
            clr_cmd_rdy <= 1'b0;
            send_resp   <= 1'b0;
            strt_cal    <= 1'b0;
            strt_hdng   <= 1'b0;
            strt_mv     <= 1'b0;
            case (state_q)
                StIdle: begin
                    if (cmd_rdy && !clr_cmd_rdy) begin
                        clr_cmd_rdy <= 1'b1;
                        case (cmd[15:13])
                            CAL: begin
                                strt_cal <= 1'b1;
                                in_cal   <= 1'b1;
                                state_q  <= StCal;
                            end
                            HDG: begin
                                dsrd_hdg  <= cmd[HDG_W-1:0];
                                strt_hdng <= 1'b1;
                                state_q   <= StHdg;
                            end
                            MOVE: begin
                                stp_lft  <= cmd[1];
                                stp_rght <= cmd[0];
                                strt_mv  <= 1'b1;
                                state_q  <= StMove;
                            end
                            SOLVE: begin
                                lft_rght_pref <= cmd[0];
                                cmd_md        <= 1'b0;
                                state_q       <= StSolve;
                            end
                            default: ;
                        endcase
                    end
                end
                StCal: begin
                    if (!clr_cmd_rdy && cal_done) begin
                        send_resp <= 1'b1;
                        in_cal    <= 1'b0;
                        state_q   <= StIdle;
                    end
                end
                StHdg, StMove: begin
                    if (!clr_cmd_rdy && mv_cmplt) begin
                        send_resp <= 1'b1;
                        stp_lft   <= 1'b0;
                        stp_rght  <= 1'b0;
                        state_q   <= StIdle;
                    end
                end
                StSolve: begin
                    if (!clr_cmd_rdy && sol_cmplt) begin
                        send_resp <= 1'b1;
                        cmd_md    <= 1'b1;
                        state_q   <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_cmd_proc.sv
// Directed bench for cmd_proc: a transaction-level reference checked every cycle,
// plus literal expectations at the key points of each scenario.
module tb_cmd_proc;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic [15:0] cmd = '0;
    logic        cmd_rdy = 1'b0;
    logic        cal_done = 1'b0;
    logic        mv_cmplt = 1'b0;
    logic        sol_cmplt = 1'b0;
    logic        clr_cmd_rdy, send_resp, strt_cal, in_cal, strt_hdng, strt_mv;
    logic        stp_lft, stp_rght, cmd_md, lft_rght_pref;
    logic [11:0] dsrd_hdg;

    int checks = 0;
    int failures = 0;
    int resp_cnt = 0;

    cmd_proc #(.HDG_W(12)) dut (
        .clk(clk), .rst_n(rst_n), .cmd(cmd), .cmd_rdy(cmd_rdy),
        .clr_cmd_rdy(clr_cmd_rdy), .send_resp(send_resp), .strt_cal(strt_cal),
        .cal_done(cal_done), .in_cal(in_cal), .strt_hdng(strt_hdng), .strt_mv(strt_mv),
        .stp_lft(stp_lft), .stp_rght(stp_rght), .dsrd_hdg(dsrd_hdg), .mv_cmplt(mv_cmplt),
        .cmd_md(cmd_md), .lft_rght_pref(lft_rght_pref), .sol_cmplt(sol_cmplt)
    );

    always #5 clk = ~clk;

    // Wrapper behaviour: the pending flag drops once the command is accepted.
    always @(negedge clk) if (clr_cmd_rdy) cmd_rdy = 1'b0;

    always @(negedge clk) if (send_resp) resp_cnt++;

    // Reference: at most one operation in flight; age counts cycles since acceptance.
    int          m_op = -1;
    int          m_age = 0;
    logic        e_clr, e_resp, e_scal, e_incal, e_shdg, e_smv, e_sl, e_sr, e_md, e_pref;
    logic [11:0] e_hdg;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_op = -1; m_age = 0;
            {e_clr, e_resp, e_scal, e_incal, e_shdg, e_smv, e_sl, e_sr} = '0;
            e_hdg = '0; e_md = 1'b1; e_pref = 1'b0;
        end else begin
            logic done;
            {e_clr, e_resp, e_scal, e_shdg, e_smv} = '0;
            if (m_op < 0) begin
                if (cmd_rdy) begin
                    e_clr = 1'b1;
                    m_age = 0;
                    case (int'(cmd[15:13]))
                        0: begin e_scal = 1'b1; e_incal = 1'b1; m_op = 0; end
                        1: begin e_hdg = cmd[11:0]; e_shdg = 1'b1; m_op = 1; end
                        2: begin e_sl = cmd[1]; e_sr = cmd[0]; e_smv = 1'b1; m_op = 2; end
                        3: begin e_pref = cmd[0]; e_md = 1'b0; m_op = 3; end
                        default: m_op = -1;
                    endcase
                end
            end else begin
                done = (m_op == 0) ? cal_done : (m_op == 3) ? sol_cmplt : mv_cmplt;
                if (m_age > 0 && done) begin
                    e_resp = 1'b1; m_op = -1;
                    e_incal = 1'b0; e_sl = 1'b0; e_sr = 1'b0; e_md = 1'b1;
                end
                m_age++;
            end
        end
    end

    wire [21:0] dut_vec = {clr_cmd_rdy, send_resp, strt_cal, in_cal, strt_hdng, strt_mv,
                           stp_lft, stp_rght, dsrd_hdg, cmd_md, lft_rght_pref};
    wire [21:0] exp_vec = {e_clr, e_resp, e_scal, e_incal, e_shdg, e_smv,
                           e_sl, e_sr, e_hdg, e_md, e_pref};

    always @(negedge clk) begin
        if (rst_n) begin
            checks++;
            if (dut_vec !== exp_vec) begin
                failures++;
                $display("FAIL model_compare t=%0t got=%h exp=%h", $time, dut_vec, exp_vec);
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", name, got, exp);
        end
    endtask

    task automatic step(input int n = 1);
        repeat (n) @(negedge clk);
        #1;
    endtask

    task automatic issue(input logic [15:0] c);
        cmd = c;
        cmd_rdy = 1'b1;
    endtask

    initial begin
        #1 rst_n = 1'b0;
        step(3);
        chk("reset_state", {10'b0, dut_vec}, 32'h2);
        rst_n = 1'b1;
        step(2);

        // Calibrate, done 100 cycles later.
        issue(16'h0000);
        step();
        chk("cal_accept", {clr_cmd_rdy, strt_cal, in_cal}, 3'b111);
        step();
        chk("cal_strobe_pulse", {strt_cal, in_cal, clr_cmd_rdy}, 3'b010);
        step(98);
        cal_done = 1'b1;
        step();
        cal_done = 1'b0;
        chk("cal_resp", {send_resp, in_cal}, 2'b10);
        step(3);

        // Stray completions while idle.
        mv_cmplt = 1'b1; sol_cmplt = 1'b1; cal_done = 1'b1;
        step();
        mv_cmplt = 1'b0; sol_cmplt = 1'b0; cal_done = 1'b0;
        step(2);
        chk("idle_done_ignored", resp_cnt, 1);

        // Heading with stale mv_cmplt spanning the strobe cycle.
        issue(16'h23FF);
        mv_cmplt = 1'b1;
        step();
        chk("hdg_strobe", {strt_hdng, dsrd_hdg}, {1'b1, 12'h3FF});
        step();
        mv_cmplt = 1'b0;
        chk("hdg_stale_done", send_resp, 1'b0);
        step(5);
        mv_cmplt = 1'b1;
        step();
        mv_cmplt = 1'b0;
        chk("hdg_resp", {send_resp, dsrd_hdg}, {1'b1, 12'h3FF});
        step(2);

        // Move with left stop.
        issue(16'h4002);
        step();
        chk("move_strobe", {strt_mv, stp_lft, stp_rght}, 3'b110);
        step(20);
        mv_cmplt = 1'b1;
        step();
        mv_cmplt = 1'b0;
        chk("move_resp", {send_resp, stp_lft, stp_rght}, 3'b100);
        step(2);

        // Solve: long run without response.
        issue(16'h6001);
        step();
        chk("solve_mode", {cmd_md, lft_rght_pref}, 2'b01);
        step(10000);
        chk("solve_no_resp", resp_cnt, 3);
        sol_cmplt = 1'b1;
        step();
        sol_cmplt = 1'b0;
        chk("solve_resp", {send_resp, cmd_md}, 2'b11);
        step(2);

        // Command pending while busy, completion coinciding with it.
        issue(16'h4001);
        step(4);
        issue(16'h2C00);
        step(6);
        chk("busy_no_accept", {clr_cmd_rdy, cmd_rdy}, 2'b01);
        mv_cmplt = 1'b1;
        step();
        mv_cmplt = 1'b0;
        chk("resp_before_accept", {send_resp, clr_cmd_rdy}, 2'b10);
        step();
        chk("accept_after_resp", {clr_cmd_rdy, strt_hdng, dsrd_hdg}, {2'b11, 12'hC00});
        step(3);
        mv_cmplt = 1'b1;
        step();
        mv_cmplt = 1'b0;
        chk("hdg2_resp", send_resp, 1'b1);
        step(2);

        // Illegal opcode.
        issue(16'hE000);
        step();
        chk("illegal_accept", {clr_cmd_rdy, strt_cal, strt_hdng, strt_mv, cmd_md}, 5'b10001);
        step(5);
        chk("illegal_no_resp", resp_cnt, 6);

        // Reset in the middle of a heading change.
        issue(16'h2123);
        step(4);
        rst_n = 1'b0;
        #1;
        chk("async_reset", {10'b0, dut_vec}, 32'h2);
        step();
        rst_n = 1'b1;
        mv_cmplt = 1'b1;
        step();
        mv_cmplt = 1'b0;
        step(2);
        chk("abort_no_resp", resp_cnt, 6);

        issue(16'h0000);
        step(10);
        cal_done = 1'b1;
        step();
        cal_done = 1'b0;
        chk("post_reset_cal_resp", {send_resp, in_cal}, 2'b10);
        step(2);
        chk("total_resp", resp_cnt, 7);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
